// File: rtl/ysyx_210544_mem_stage_pkg.sv
// ysyx_210544_mem_stage_pkg: shared opcodes, size codes, FSM states and helpers for the memory stage
package ysyx_210544_mem_stage_pkg;

    localparam logic [7:0] OP_LB  = 8'h10;
    localparam logic [7:0] OP_LH  = 8'h11;
    localparam logic [7:0] OP_LW  = 8'h12;
    localparam logic [7:0] OP_LD  = 8'h13;
    localparam logic [7:0] OP_LBU = 8'h14;
    localparam logic [7:0] OP_LHU = 8'h15;
    localparam logic [7:0] OP_LWU = 8'h16;
    localparam logic [7:0] OP_SB  = 8'h18;
    localparam logic [7:0] OP_SH  = 8'h19;
    localparam logic [7:0] OP_SW  = 8'h1a;
    localparam logic [7:0] OP_SD  = 8'h1b;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_e;

    typedef struct packed {
        logic [7:0]  opcode;
        logic [63:0] pc;
        logic [31:0] inst;
        logic [63:0] op1;
        logic [63:0] op2;
        logic [63:0] op3;
        logic [4:0]  rd;
        logic        rd_wen;
        logic [63:0] rd_wdata;
    } mem_lat_t;

    function automatic logic is_load(input logic [7:0] op);
        return op inside {OP_LB, OP_LH, OP_LW, OP_LD, OP_LBU, OP_LHU, OP_LWU};
    endfunction

    function automatic logic is_store(input logic [7:0] op);
        return op inside {OP_SB, OP_SH, OP_SW, OP_SD};
    endfunction

    function automatic logic is_unsigned(input logic [7:0] op);
        return op inside {OP_LBU, OP_LHU, OP_LWU};
    endfunction

    function automatic logic [1:0] op_size(input logic [7:0] op);
        return (op inside {OP_LB, OP_LBU, OP_SB}) ? SZ_B :
               (op inside {OP_LH, OP_LHU, OP_SH}) ? SZ_H :
               (op inside {OP_LW, OP_LWU, OP_SW}) ? SZ_W : SZ_D;
    endfunction

    function automatic logic [7:0] size_mask(input logic [1:0] sz);
        return sz == SZ_B ? 8'h01 : sz == SZ_H ? 8'h03 : sz == SZ_W ? 8'h0f : 8'hff;
    endfunction

endpackage

// File: rtl/ysyx_210544_memU.sv
// ysyx_210544_memU: combinational store lane alignment and load extract/extend
module ysyx_210544_memU
    import ysyx_210544_mem_stage_pkg::*;
(
    input  logic [7:0]  opcode,
    input  logic [2:0]  off,
    input  logic [63:0] op3,
    input  logic [63:0] rdata,
    output logic [1:0]  size,
    output logic [7:0]  wstrb,
    output logic [63:0] wdata,
    output logic [63:0] ldata
);
    logic [5:0]  sh;
    logic [63:0] sft;
    logic        sx;
    always_comb begin
        size  = op_size(opcode);
        sh    = {off, 3'b000};
        wstrb = size_mask(size) << off;
        wdata = op3 << sh;
        sft   = rdata >> sh;
        sx    = ~is_unsigned(opcode);
        ldata = size == SZ_B ? {{56{sft[7] & sx}}, sft[7:0]} :
                size == SZ_H ? {{48{sft[15] & sx}}, sft[15:0]} :
                size == SZ_W ? {{32{sft[31] & sx}}, sft[31:0]} : sft;
    end
endmodule

// File: rtl/ysyx_210544_mem_stage.sv
// ysyx_210544_mem_stage: memory-access stage FSM bridging execute, data port and write-back
module ysyx_210544_mem_stage
    import ysyx_210544_mem_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_mem_executed_req,
    output logic        o_mem_executed_ack,
    output logic        o_mem_memoryed_req,
    input  logic        i_mem_memoryed_ack,
    input  logic [7:0]  i_mem_inst_opcode,
    input  logic [63:0] i_mem_pc,
    input  logic [31:0] i_mem_inst,
    input  logic [63:0] i_mem_op1,
    input  logic [63:0] i_mem_op2,
    input  logic [63:0] i_mem_op3,
    input  logic [4:0]  i_mem_rd,
    input  logic        i_mem_rd_wen,
    input  logic [63:0] i_mem_rd_wdata,
    output logic        o_dmem_req,
    input  logic        i_dmem_ack,
    output logic        o_dmem_wen,
    output logic [63:0] o_dmem_addr,
    output logic [1:0]  o_dmem_size,
    output logic [7:0]  o_dmem_wstrb,
    output logic [63:0] o_dmem_wdata,
    input  logic [63:0] i_dmem_rdata,
    output logic [63:0] o_mem_pc,
    output logic [31:0] o_mem_inst,
    output logic [4:0]  o_mem_rd,
    output logic        o_mem_rd_wen,
    output logic [63:0] o_mem_rd_wdata
);
    state_e      state_q, state_d;
    mem_lat_t    lat_q, lat_d;
    logic        accept, acc, done;
    logic [63:0] addr, wdata, ldata;
    logic [1:0]  size;
    logic [7:0]  wstrb;

    ysyx_210544_memU u_memu (
        .opcode (lat_q.opcode),
        .off    (addr[2:0]),
        .op3    (lat_q.op3),
        .rdata  (i_dmem_rdata),
        .size   (size),
        .wstrb  (wstrb),
        .wdata  (wdata),
        .ldata  (ldata)
    );

    always_comb begin
        accept  = i_mem_executed_req & (state_q == S_IDLE);
        state_d = state_q;
        lat_d   = lat_q;
        if (accept) begin
            lat_d.opcode   = i_mem_inst_opcode;
            lat_d.pc       = i_mem_pc;
            lat_d.inst     = i_mem_inst;
            lat_d.op1      = i_mem_op1;
            lat_d.op2      = i_mem_op2;
            lat_d.op3      = i_mem_op3;
            lat_d.rd       = i_mem_rd;
            lat_d.rd_wen   = i_mem_rd_wen & ~is_store(i_mem_inst_opcode);
            lat_d.rd_wdata = i_mem_rd_wdata;
            state_d        = (is_load(i_mem_inst_opcode) | is_store(i_mem_inst_opcode)) ? S_ACCESS : S_DONE;
        end else if (state_q == S_ACCESS && i_dmem_ack) begin
            state_d        = S_DONE;
            lat_d.rd_wdata = is_load(lat_q.opcode) ? ldata : lat_q.rd_wdata;
        end else if (state_q == S_DONE && i_mem_memoryed_ack) begin
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            lat_q   <= '0;
        end else begin
            state_q <= state_d;
            lat_q   <= lat_d;
        end
    end

    assign addr               = lat_q.op1 + lat_q.op2;
    assign acc                = state_q == S_ACCESS;
    assign done               = state_q == S_DONE;
    assign o_mem_executed_ack = state_q == S_IDLE;
    assign o_mem_memoryed_req = done;
    assign o_dmem_req         = acc;
    assign o_dmem_wen         = acc & is_store(lat_q.opcode);
    assign o_dmem_addr        = acc ? addr : '0;
    assign o_dmem_size        = acc ? size : '0;
    assign o_dmem_wstrb       = o_dmem_wen ? wstrb : '0;
    assign o_dmem_wdata       = o_dmem_wen ? wdata : '0;
    assign o_mem_pc           = done ? lat_q.pc : '0;
    assign o_mem_inst         = done ? lat_q.inst : '0;
    assign o_mem_rd           = done ? lat_q.rd : '0;
    assign o_mem_rd_wen       = done & lat_q.rd_wen;
    assign o_mem_rd_wdata     = done ? lat_q.rd_wdata : '0;
endmodule

// File: tb/tb_ysyx_210544_mem_stage.sv
// tb_ysyx_210544_mem_stage: directed scenario checks for the memory stage
module tb_ysyx_210544_mem_stage;
    import ysyx_210544_mem_stage_pkg::*;

    logic        clk = 0, rst = 1;
    logic        i_mem_executed_req = 0, i_mem_memoryed_ack = 0, i_dmem_ack = 0;
    logic [7:0]  i_mem_inst_opcode = 0;
    logic [63:0] i_mem_pc = 0, i_mem_op1 = 0, i_mem_op2 = 0, i_mem_op3 = 0, i_mem_rd_wdata = 0, i_dmem_rdata = 0;
    logic [31:0] i_mem_inst = 0;
    logic [4:0]  i_mem_rd = 0;
    logic        i_mem_rd_wen = 0;
    logic        o_mem_executed_ack, o_mem_memoryed_req, o_dmem_req, o_dmem_wen, o_mem_rd_wen;
    logic [63:0] o_dmem_addr, o_dmem_wdata, o_mem_pc, o_mem_rd_wdata;
    logic [1:0]  o_dmem_size;
    logic [7:0]  o_dmem_wstrb;
    logic [31:0] o_mem_inst;
    logic [4:0]  o_mem_rd;
    int tests = 0, fails = 0;

    ysyx_210544_mem_stage dut (
        .clk(clk), .rst(rst),
        .i_mem_executed_req(i_mem_executed_req), .o_mem_executed_ack(o_mem_executed_ack),
        .o_mem_memoryed_req(o_mem_memoryed_req), .i_mem_memoryed_ack(i_mem_memoryed_ack),
        .i_mem_inst_opcode(i_mem_inst_opcode), .i_mem_pc(i_mem_pc), .i_mem_inst(i_mem_inst),
        .i_mem_op1(i_mem_op1), .i_mem_op2(i_mem_op2), .i_mem_op3(i_mem_op3),
        .i_mem_rd(i_mem_rd), .i_mem_rd_wen(i_mem_rd_wen), .i_mem_rd_wdata(i_mem_rd_wdata),
        .o_dmem_req(o_dmem_req), .i_dmem_ack(i_dmem_ack), .o_dmem_wen(o_dmem_wen),
        .o_dmem_addr(o_dmem_addr), .o_dmem_size(o_dmem_size), .o_dmem_wstrb(o_dmem_wstrb),
        .o_dmem_wdata(o_dmem_wdata), .i_dmem_rdata(i_dmem_rdata),
        .o_mem_pc(o_mem_pc), .o_mem_inst(o_mem_inst), .o_mem_rd(o_mem_rd),
        .o_mem_rd_wen(o_mem_rd_wen), .o_mem_rd_wdata(o_mem_rd_wdata)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [7:0] op, input logic [63:0] op1, input logic [63:0] op2,
                         input logic [63:0] op3, input logic [63:0] rdw);
        i_mem_executed_req = 1;
        i_mem_inst_opcode  = op;
        i_mem_pc           = 64'h8000_1000;
        i_mem_inst         = 32'h1234_5678;
        i_mem_op1          = op1;
        i_mem_op2          = op2;
        i_mem_op3          = op3;
        i_mem_rd           = 5'd7;
        i_mem_rd_wen       = 1;
        i_mem_rd_wdata     = rdw;
        tick();
        i_mem_executed_req = 0;
        i_mem_op1          = 0;
        i_mem_op3          = 0;
        i_mem_rd_wdata     = 0;
    endtask

    task automatic retire();
        i_mem_memoryed_ack = 1;
        tick();
        i_mem_memoryed_ack = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        tick();
        tick();
        tests++;
        if ({o_mem_executed_ack, o_mem_memoryed_req, o_dmem_req, o_dmem_wstrb, o_mem_rd_wdata, o_mem_pc} !== {1'b1, 1'b0, 1'b0, 8'h0, 64'h0, 64'h0}) begin
            fails++;
            $display("FAIL reset: ack=%b mreq=%b dreq=%b wstrb=%h wdata=%h pc=%h, want ack=1 rest 0",
                     o_mem_executed_ack, o_mem_memoryed_req, o_dmem_req, o_dmem_wstrb, o_mem_rd_wdata, o_mem_pc);
        end
        rst = 0;
    endtask

    task automatic test_nonmem();
        issue(8'h01, 64'h5, 64'h6, 64'h0, 64'h1234);
        tests++;
        if ({o_mem_memoryed_req, o_dmem_req, o_mem_executed_ack, o_mem_rd_wdata, o_mem_rd_wen, o_mem_rd, o_mem_pc, o_mem_inst} !==
            {1'b1, 1'b0, 1'b0, 64'h1234, 1'b1, 5'd7, 64'h8000_1000, 32'h1234_5678}) begin
            fails++;
            $display("FAIL nonmem: mreq=%b dreq=%b eack=%b wdata=%h wen=%b rd=%0d pc=%h inst=%h, want 1 0 0 1234 1 7 80001000 12345678",
                     o_mem_memoryed_req, o_dmem_req, o_mem_executed_ack, o_mem_rd_wdata, o_mem_rd_wen, o_mem_rd, o_mem_pc, o_mem_inst);
        end
        retire();
        tests++;
        if ({o_mem_memoryed_req, o_mem_executed_ack, o_mem_rd_wdata, o_dmem_req} !== {1'b0, 1'b1, 64'h0, 1'b0}) begin
            fails++;
            $display("FAIL nonmem_retire: mreq=%b eack=%b wdata=%h dreq=%b, want 0 1 0 0",
                     o_mem_memoryed_req, o_mem_executed_ack, o_mem_rd_wdata, o_dmem_req);
        end
    endtask

    task automatic test_load(input string name, input logic [7:0] op, input logic [63:0] base, input logic [63:0] ofs,
                             input logic [1:0] sz, input logic [63:0] rdata, input logic [63:0] exp);
        issue(op, base, ofs, 64'h0, 64'hdead);
        tests++;
        if ({o_dmem_req, o_dmem_wen, o_dmem_addr, o_dmem_size, o_dmem_wstrb, o_mem_memoryed_req} !== {1'b1, 1'b0, base + ofs, sz, 8'h0, 1'b0}) begin
            fails++;
            $display("FAIL %s_req: req=%b wen=%b addr=%h size=%0d wstrb=%h mreq=%b, want 1 0 %h %0d 00 0",
                     name, o_dmem_req, o_dmem_wen, o_dmem_addr, o_dmem_size, o_dmem_wstrb, o_mem_memoryed_req, base + ofs, sz);
        end
        i_dmem_ack   = 1;
        i_dmem_rdata = rdata;
        tick();
        i_dmem_ack   = 0;
        i_dmem_rdata = 0;
        tests++;
        if ({o_dmem_req, o_mem_memoryed_req, o_mem_rd_wdata, o_mem_rd_wen} !== {1'b0, 1'b1, exp, 1'b1}) begin
            fails++;
            $display("FAIL %s_data: dreq=%b mreq=%b wdata=%h wen=%b, want 0 1 %h 1",
                     name, o_dmem_req, o_mem_memoryed_req, o_mem_rd_wdata, o_mem_rd_wen, exp);
        end
        retire();
    endtask

    task automatic test_store(input string name, input logic [7:0] op, input logic [63:0] addr, input logic [63:0] op3,
                              input logic [1:0] sz, input logic [7:0] strb, input logic [63:0] wd);
        issue(op, addr, 64'h0, op3, 64'hbeef);
        tests++;
        if ({o_dmem_req, o_dmem_wen, o_dmem_addr, o_dmem_size, o_dmem_wstrb, o_dmem_wdata} !== {1'b1, 1'b1, addr, sz, strb, wd}) begin
            fails++;
            $display("FAIL %s_req: req=%b wen=%b addr=%h size=%0d wstrb=%h wdata=%h, want 1 1 %h %0d %h %h",
                     name, o_dmem_req, o_dmem_wen, o_dmem_addr, o_dmem_size, o_dmem_wstrb, o_dmem_wdata, addr, sz, strb, wd);
        end
        i_dmem_ack = 1;
        tick();
        i_dmem_ack = 0;
        tests++;
        if ({o_mem_memoryed_req, o_mem_rd_wen, o_dmem_req, o_dmem_wen, o_dmem_wstrb} !== {1'b1, 1'b0, 1'b0, 1'b0, 8'h0}) begin
            fails++;
            $display("FAIL %s_wb: mreq=%b rd_wen=%b dreq=%b wen=%b wstrb=%h, want 1 0 0 0 00",
                     name, o_mem_memoryed_req, o_mem_rd_wen, o_dmem_req, o_dmem_wen, o_dmem_wstrb);
        end
        retire();
    endtask

    task automatic test_backpressure();
        issue(OP_LD, 64'h8000_0010, 64'h0, 64'h0, 64'h0);
        for (int i = 0; i < 5; i++) begin
            i_dmem_rdata = 64'hffff_ffff_ffff_ffff;
            tests++;
            if ({o_dmem_req, o_dmem_addr, o_dmem_size, o_dmem_wen, o_mem_executed_ack, o_mem_memoryed_req} !==
                {1'b1, 64'h8000_0010, SZ_D, 1'b0, 1'b0, 1'b0}) begin
                fails++;
                $display("FAIL ld_wait%0d: req=%b addr=%h size=%0d wen=%b eack=%b mreq=%b, want 1 80000010 3 0 0 0",
                         i, o_dmem_req, o_dmem_addr, o_dmem_size, o_dmem_wen, o_mem_executed_ack, o_mem_memoryed_req);
            end
            tick();
        end
        i_dmem_ack   = 1;
        i_dmem_rdata = 64'h1122_3344_5566_7788;
        tick();
        i_dmem_ack   = 0;
        i_dmem_rdata = 0;
        for (int i = 0; i < 4; i++) begin
            tests++;
            if ({o_mem_memoryed_req, o_mem_rd_wdata, o_mem_executed_ack, o_dmem_req} !== {1'b1, 64'h1122_3344_5566_7788, 1'b0, 1'b0}) begin
                fails++;
                $display("FAIL ld_hold%0d: mreq=%b wdata=%h eack=%b dreq=%b, want 1 1122334455667788 0 0",
                         i, o_mem_memoryed_req, o_mem_rd_wdata, o_mem_executed_ack, o_dmem_req);
            end
            if (i < 3) tick();
        end
        retire();
        tests++;
        if ({o_mem_executed_ack, o_mem_memoryed_req} !== 2'b10) begin
            fails++;
            $display("FAIL ld_release: eack=%b mreq=%b, want 1 0", o_mem_executed_ack, o_mem_memoryed_req);
        end
    endtask

    task automatic test_stray_acks();
        i_dmem_ack         = 1;
        i_mem_memoryed_ack = 1;
        tick();
        tick();
        i_dmem_ack         = 0;
        i_mem_memoryed_ack = 0;
        tests++;
        if ({o_mem_executed_ack, o_mem_memoryed_req, o_dmem_req} !== 3'b100) begin
            fails++;
            $display("FAIL stray_ack: eack=%b mreq=%b dreq=%b, want 1 0 0", o_mem_executed_ack, o_mem_memoryed_req, o_dmem_req);
        end
    endtask

    task automatic test_reset_mid_access();
        issue(OP_SW, 64'h8000_0020, 64'h0, 64'h55aa, 64'h0);
        tests++;
        if (o_dmem_req !== 1'b1) begin
            fails++;
            $display("FAIL rst_mid_pre: dreq=%b, want 1", o_dmem_req);
        end
        rst = 1;
        tick();
        rst = 0;
        tests++;
        if ({o_dmem_req, o_dmem_wen, o_dmem_wstrb, o_dmem_addr, o_mem_memoryed_req, o_mem_executed_ack, o_mem_rd_wdata} !==
            {1'b0, 1'b0, 8'h0, 64'h0, 1'b0, 1'b1, 64'h0}) begin
            fails++;
            $display("FAIL rst_mid: dreq=%b wen=%b wstrb=%h addr=%h mreq=%b eack=%b wdata=%h, want 0 0 00 0 0 1 0",
                     o_dmem_req, o_dmem_wen, o_dmem_wstrb, o_dmem_addr, o_mem_memoryed_req, o_mem_executed_ack, o_mem_rd_wdata);
        end
        test_load("lw_after_rst", OP_LW, 64'h8000_0004, 64'h0, SZ_W, 64'h8765_4321_0000_0000, 64'hffff_ffff_8765_4321);
    endtask

    initial begin
        test_reset();
        test_nonmem();
        test_load("lb",  OP_LB,  64'h8000_0000, 64'h3, SZ_B, 64'h0000_0000_8000_0000, 64'hffff_ffff_ffff_ff80);
        test_load("lbu", OP_LBU, 64'h8000_0000, 64'h3, SZ_B, 64'h0000_0000_8000_0000, 64'h0000_0000_0000_0080);
        test_load("lh",  OP_LH,  64'h8000_0002, 64'h0, SZ_H, 64'h0000_0000_8001_0000, 64'hffff_ffff_ffff_8001);
        test_load("lhu", OP_LHU, 64'h8000_0002, 64'h0, SZ_H, 64'h0000_0000_8001_0000, 64'h0000_0000_0000_8001);
        test_load("lwu", OP_LWU, 64'h8000_0004, 64'h0, SZ_W, 64'h8765_4321_0000_0000, 64'h0000_0000_8765_4321);
        test_load("lw_pos", OP_LW, 64'h8000_0000, 64'h0, SZ_W, 64'hffff_ffff_1234_5678, 64'h0000_0000_1234_5678);
        test_store("sh", OP_SH, 64'h8000_0006, 64'hABCD, SZ_H, 8'hc0, 64'hABCD_0000_0000_0000);
        test_store("sb", OP_SB, 64'h8000_0001, 64'h5a, SZ_B, 8'h02, 64'h0000_0000_0000_5a00);
        test_store("sd_cross", OP_SD, 64'h8000_0005, 64'h0102_0304_0506_0708, SZ_D, 8'he0, 64'h0607_0800_0000_0000);
        test_backpressure();
        test_stray_acks();
        test_reset_mid_access();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
